// File: rtl/binary_neuron_layer.sv
// binary_neuron_layer: NUM_NEURONS binary-weight neurons sharing one activation
// vector, LANES activations per beat, start/valid/ready result handshake.
`default_nettype none

module binary_neuron_layer #(
   parameter int IN_SIZE     = 784,
   parameter int WIDTH       = 8,
   parameter int NUM_NEURONS = 16,
   parameter int LANES       = 8,
   parameter int ACC_W       = 32,
   parameter int BIAS_W      = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     start,
   input  logic [WIDTH-1:0]         in_data     [0:IN_SIZE-1],
   input  logic                     weight      [0:NUM_NEURONS-1][0:IN_SIZE-1],
   input  logic signed [BIAS_W-1:0] bias        [0:NUM_NEURONS-1],
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  neuron_out  [0:NUM_NEURONS-1],
   output logic                     neuron_sign [0:NUM_NEURONS-1],
   output logic                     out_valid,
   output logic                     busy
);

   localparam int ADDR_W = $clog2(IN_SIZE + LANES);
   localparam int IDX_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam logic [ADDR_W-1:0] C_IN_SIZE = ADDR_W'(IN_SIZE);
   localparam logic [ADDR_W-1:0] C_LANES   = ADDR_W'(LANES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_BIAS  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic signed [ACC_W-1:0]  acc_q [0:NUM_NEURONS-1];
   logic signed [ACC_W-1:0]  acc_d [0:NUM_NEURONS-1];
   logic signed [ACC_W-1:0]  neuron_out_q [0:NUM_NEURONS-1];
   logic signed [ACC_W-1:0]  neuron_out_d [0:NUM_NEURONS-1];
   logic                     neuron_sign_q [0:NUM_NEURONS-1];
   logic                     neuron_sign_d [0:NUM_NEURONS-1];
   logic                     out_valid_q, out_valid_d;
   logic                     busy_q, busy_d;

   logic [ADDR_W-1:0]        lane_idx [0:LANES-1];
   logic                     lane_ok  [0:LANES-1];
   logic [ACC_W-1:0]         lane_x   [0:LANES-1];
   logic signed [ACC_W-1:0]  beat_sum [0:NUM_NEURONS-1];
   logic                     last_beat;

   // Per-beat partial sums; lanes past the end of the vector contribute nothing.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_idx[l] = addr_q + ADDR_W'(l);
         lane_ok[l]  = (lane_idx[l] < C_IN_SIZE);
         lane_x[l]   = lane_ok[l] ? ACC_W'(in_data[lane_idx[l][IDX_W-1:0]]) : '0;
      end
      for (int n = 0; n < NUM_NEURONS; n++) begin
         beat_sum[n] = '0;
         for (int l = 0; l < LANES; l++) begin
            if (lane_ok[l]) begin
               if (weight[n][lane_idx[l][IDX_W-1:0]])
                  beat_sum[n] = beat_sum[n] + $signed(lane_x[l]);
               else
                  beat_sum[n] = beat_sum[n] - $signed(lane_x[l]);
            end
         end
      end
      last_beat = ((addr_q + C_LANES) >= C_IN_SIZE);
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      acc_d         = acc_q;
      neuron_out_d  = neuron_out_q;
      neuron_sign_d = neuron_sign_q;
      out_valid_d   = out_valid_q;
      busy_d        = busy_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               addr_d  = '0;
               busy_d  = 1'b1;
               for (int n = 0; n < NUM_NEURONS; n++) acc_d[n] = '0;
            end
         end
         S_ACCUM: begin
            if (en) begin
               for (int n = 0; n < NUM_NEURONS; n++)
                  acc_d[n] = acc_q[n] + beat_sum[n];
               addr_d = addr_q + C_LANES;
               if (last_beat) state_d = S_BIAS;
            end
         end
         S_BIAS: begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
               neuron_out_d[n]  = acc_q[n] + ACC_W'(bias[n]);
               neuron_sign_d[n] = ~neuron_out_d[n][ACC_W-1];
            end
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            // Results stay on the outputs after the handshake; only valid drops.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            acc_q[n]         <= '0;
            neuron_out_q[n]  <= '0;
            neuron_sign_q[n] <= 1'b0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            acc_q[n]         <= acc_d[n];
            neuron_out_q[n]  <= neuron_out_d[n];
            neuron_sign_q[n] <= neuron_sign_d[n];
         end
      end
   end

   assign neuron_out  = neuron_out_q;
   assign neuron_sign = neuron_sign_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_neuron_layer.sv
// tb_binary_neuron_layer: three configurations of binary_neuron_layer checked
// against a plain-arithmetic dot-product model with latency expectations.
`default_nettype none

module tb_binary_neuron_layer;

   logic clk;
   logic rst_n;
   logic en;
   logic start;
   logic out_ready;
   int   sel;

   logic [7:0]        data [0:783];
   logic              wt   [0:15][0:783];
   logic signed [7:0] bs   [0:15];

   // Configuration A: IN_SIZE=4, LANES=2, 2 neurons
   logic [7:0]         a_data [0:3];
   logic               a_wt   [0:1][0:3];
   logic signed [7:0]  a_bs   [0:1];
   logic signed [31:0] a_out  [0:1];
   logic               a_sign [0:1];
   logic               a_valid, a_busy, a_start;

   // Configuration B: IN_SIZE=5, LANES=2, 2 neurons
   logic [7:0]         b_data [0:4];
   logic               b_wt   [0:1][0:4];
   logic signed [7:0]  b_bs   [0:1];
   logic signed [31:0] b_out  [0:1];
   logic               b_sign [0:1];
   logic               b_valid, b_busy, b_start;

   // Configuration C: defaults
   logic signed [31:0] c_out  [0:15];
   logic               c_sign [0:15];
   logic               c_valid, c_busy, c_start;

   int   obs_out  [0:15];
   logic obs_sign [0:15];
   logic obs_valid, obs_busy;

   int n_pass;
   int n_chk;

   assign a_start = start && (sel == 0);
   assign b_start = start && (sel == 1);
   assign c_start = start && (sel == 2);

   always_comb begin
      for (int i = 0; i < 4; i++) a_data[i] = data[i];
      for (int i = 0; i < 5; i++) b_data[i] = data[i];
      for (int n = 0; n < 2; n++) begin
         a_bs[n] = bs[n];
         b_bs[n] = bs[n];
         for (int i = 0; i < 4; i++) a_wt[n][i] = wt[n][i];
         for (int i = 0; i < 5; i++) b_wt[n][i] = wt[n][i];
      end
   end

   always_comb begin
      for (int n = 0; n < 16; n++) begin
         obs_out[n]  = 0;
         obs_sign[n] = 1'b0;
      end
      obs_valid = 1'b0;
      obs_busy  = 1'b0;
      case (sel)
         0: begin
            for (int n = 0; n < 2; n++) begin
               obs_out[n]  = int'(a_out[n]);
               obs_sign[n] = a_sign[n];
            end
            obs_valid = a_valid;
            obs_busy  = a_busy;
         end
         1: begin
            for (int n = 0; n < 2; n++) begin
               obs_out[n]  = int'(b_out[n]);
               obs_sign[n] = b_sign[n];
            end
            obs_valid = b_valid;
            obs_busy  = b_busy;
         end
         default: begin
            for (int n = 0; n < 16; n++) begin
               obs_out[n]  = int'(c_out[n]);
               obs_sign[n] = c_sign[n];
            end
            obs_valid = c_valid;
            obs_busy  = c_busy;
         end
      endcase
   end

   binary_neuron_layer #(
      .IN_SIZE(4), .WIDTH(8), .NUM_NEURONS(2), .LANES(2), .ACC_W(32), .BIAS_W(8)
   ) u_dut_a (
      .clk(clk), .reset(rst_n), .en(en), .start(a_start),
      .in_data(a_data), .weight(a_wt), .bias(a_bs), .out_ready(out_ready),
      .neuron_out(a_out), .neuron_sign(a_sign), .out_valid(a_valid), .busy(a_busy)
   );

   binary_neuron_layer #(
      .IN_SIZE(5), .WIDTH(8), .NUM_NEURONS(2), .LANES(2), .ACC_W(32), .BIAS_W(8)
   ) u_dut_b (
      .clk(clk), .reset(rst_n), .en(en), .start(b_start),
      .in_data(b_data), .weight(b_wt), .bias(b_bs), .out_ready(out_ready),
      .neuron_out(b_out), .neuron_sign(b_sign), .out_valid(b_valid), .busy(b_busy)
   );

   binary_neuron_layer u_dut_c (
      .clk(clk), .reset(rst_n), .en(en), .start(c_start),
      .in_data(data), .weight(wt), .bias(bs), .out_ready(out_ready),
      .neuron_out(c_out), .neuron_sign(c_sign), .out_valid(c_valid), .busy(c_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cfg(output int nin, output int nl, output int nn);
      case (sel)
         0:       begin nin = 4;   nl = 2; nn = 2;  end
         1:       begin nin = 5;   nl = 2; nn = 2;  end
         default: begin nin = 784; nl = 8; nn = 16; end
      endcase
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < 784; i++) data[i] = 8'($urandom_range(0, 255));
      for (int n = 0; n < 16; n++) begin
         bs[n] = 8'($urandom_range(0, 255));
         for (int i = 0; i < 784; i++) wt[n][i] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic load_case1();
      data[0] = 8'd10; data[1] = 8'd20; data[2] = 8'd30; data[3] = 8'd40;
      for (int i = 0; i < 4; i++) begin
         wt[0][i] = 1'b1;
         wt[1][i] = (i % 2 == 1);
      end
      bs[0] = 8'sd0;
      bs[1] = -8'sd5;
   endtask

   // One full transaction: start, optional en stall, optional backpressure.
   task automatic run(input int en_lo, input int bp);
      int  nin, nl, nn, nb, lat, cyc;
      int  exp_out [0:15];
      bit  got, busy_ok;
      cfg(nin, nl, nn);
      for (int n = 0; n < nn; n++) begin
         exp_out[n] = int'(bs[n]);
         for (int i = 0; i < nin; i++)
            exp_out[n] += wt[n][i] ? int'(data[i]) : -int'(data[i]);
      end
      nb  = (nin + nl - 1) / nl;
      lat = nb + 1 + en_lo;

      @(negedge clk);
      start = 1'b1;
      en    = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_rise", int'(obs_busy), 1);
      cyc = 0;
      got = 1'b0;
      busy_ok = 1'b1;
      while (!got && cyc < lat + 20) begin
         @(negedge clk);
         start = 1'b0;
         en = !(en_lo > 0 && cyc >= 1 && cyc < 1 + en_lo);
         cyc++;
         @(posedge clk);
         #1;
         if (obs_valid) got = 1'b1;
         else if (!obs_busy) busy_ok = 1'b0;
      end
      en = 1'b1;
      chk("latency", got ? cyc : -1, lat);
      chk("busy_held", int'(busy_ok), 1);
      for (int n = 0; n < nn; n++) begin
         chk($sformatf("out%0d", n), obs_out[n], exp_out[n]);
         chk($sformatf("sign%0d", n), int'(obs_sign[n]), int'(exp_out[n] >= 0));
      end
      for (int b = 0; b < bp; b++) begin
         @(negedge clk);
         start = (b == 1);
         @(posedge clk);
         #1;
         chk("bp_valid", int'(obs_valid), 1);
         chk("bp_busy", int'(obs_busy), 1);
         chk("bp_out0", obs_out[0], exp_out[0]);
      end
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_valid", int'(obs_valid), 0);
      chk("hs_busy", int'(obs_busy), 0);
      chk("hold_out0", obs_out[0], exp_out[0]);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_stay", int'(obs_busy), 0);
   endtask

   initial begin
      int nin, nl, nn;
      n_pass = 0;
      n_chk  = 0;
      rst_n = 1'b0;
      en = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      sel = 0;
      for (int i = 0; i < 784; i++) data[i] = 8'd0;
      for (int n = 0; n < 16; n++) begin
         bs[n] = 8'sd0;
         for (int i = 0; i < 784; i++) wt[n][i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", int'(obs_valid), 0);
      chk("rst_busy", int'(obs_busy), 0);
      chk("rst_out0", obs_out[0], 0);
      chk("rst_sign0", int'(obs_sign[0]), 0);

      // Basic case
      load_case1();
      run(0, 0);
      chk("c1_n0", obs_out[0], 100);
      chk("c1_n1", obs_out[1], 15);

      // Tail masking
      sel = 1;
      for (int i = 0; i < 5; i++) data[i] = 8'(i + 1);
      for (int n = 0; n < 2; n++) begin
         bs[n] = 8'sd3;
         for (int i = 0; i < 784; i++) wt[n][i] = 1'b0;
      end
      run(0, 0);
      chk("tail_n0", obs_out[0], -12);

      // en stall, then backpressure with a start pulse in DONE
      sel = 0;
      load_case1();
      run(2, 0);
      run(0, 5);
      chk("bp_n1", obs_out[1], 15);

      // Asynchronous reset mid-ACCUM
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(obs_valid), 0);
      chk("arst_busy", int'(obs_busy), 0);
      chk("arst_out0", obs_out[0], 0);
      chk("arst_out1", obs_out[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("arst_discard", int'(obs_valid), 0);
      run(0, 0);
      chk("arst_c1_n0", obs_out[0], 100);

      // Default configuration, saturating activations
      sel = 2;
      for (int i = 0; i < 784; i++) data[i] = 8'd255;
      for (int n = 0; n < 16; n++) begin
         bs[n] = 8'sd0;
         for (int i = 0; i < 784; i++) wt[n][i] = 1'b0;
      end
      run(0, 0);
      cfg(nin, nl, nn);
      for (int n = 0; n < nn; n++) chk($sformatf("def_n%0d", n), obs_out[n], -199920);

      // Randomized transactions on every configuration
      for (int t = 0; t < 12; t++) begin
         sel = t % 2;
         randomize_inputs();
         run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      sel = 2;
      randomize_inputs();
      run(int'($urandom_range(0, 3)), 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/binary_neuron_layer.md
# binary_neuron_layer

Parametrised successor to the single-neuron input stage. It computes NUM_NEURONS binary-weight neurons in parallel over a shared IN_SIZE-element activation vector and consumes LANES inputs per cycle. Each weight bit selects +x or -x; a signed per-neuron bias is added after accumulation. Results are presented through a start/valid/ready handshake to the next layer, with a sign bit provided as the binarised activation.

## Interface
- IN_SIZE, 784, number of input activations.
- WIDTH, 8, unsigned activation width.
- NUM_NEURONS, 16, neurons computed in parallel.
- LANES, 8, inputs consumed per beat (1..IN_SIZE).
- ACC_W, 32, signed accumulator and output width; must be greater than WIDTH + clog2(IN_SIZE) + 1.
- BIAS_W, 8, signed bias width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  beat enable; ACCUM holds when low.
- start  in  1  begin a computation; sampled only in IDLE.
- in_data[0:IN_SIZE-1]  in  WIDTH  unsigned activations.
- weight[0:NUM_NEURONS-1][0:IN_SIZE-1]  in  1  1 = +x, 0 = -x.
- bias[0:NUM_NEURONS-1]  in  BIAS_W  signed bias.
- out_ready  in  1  consumer accepts results.
- neuron_out[0:NUM_NEURONS-1]  out  ACC_W  signed weighted sum + bias.
- neuron_sign[0:NUM_NEURONS-1]  out  1  1 when neuron_out >= 0.
- out_valid  out  1  results valid.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, BIAS, DONE.
- IDLE -> ACCUM on start: clear all accumulators and set addr = 0.
- ACCUM, with en high: for each neuron n and lane l with i = addr + l, add +in_data[i] if weight[n][i] is 1, or -in_data[i] if it is 0.
  - Activations are zero-extended to ACC_W before negation.
  - Lanes with i >= IN_SIZE contribute 0.
  - addr += LANES.
  - After beat N_BEATS = ceil(IN_SIZE/LANES), go to BIAS.
- ACCUM, with en low: accumulators, addr and state all hold.
- BIAS: add sign-extended bias to each accumulator; register neuron_out and neuron_sign; set out_valid; go to DONE. en is ignored in BIAS.
- DONE: hold outputs and out_valid. When out_valid and out_ready are both high at an edge, go to IDLE and clear out_valid. neuron_out and neuron_sign keep their last values.
- start is ignored outside IDLE. start together with out_ready in DONE does not restart; a new start must arrive in IDLE.
- in_data, weight and bias must stay stable from the start edge until out_valid. The block does not capture them.
- Arithmetic is two's complement. Overflow wraps; it cannot occur when the ACC_W rule above holds.
- Reset asserted (low) at any time:
  - state goes to IDLE, addr to 0, accumulators to 0;
  - neuron_out is 0, neuron_sign is 0, out_valid is 0, busy is 0;
  - any in-flight computation is discarded.

## Timing
- start sampled at edge k. Beats occur at edges k+1 .. k+N_BEATS when en is high throughout.
- Bias is added at edge k+N_BEATS+1; out_valid is high from that edge.
- Latency from start edge to out_valid is N_BEATS+1 edges, plus one edge for each cycle in ACCUM with en low.
- busy rises at edge k and falls at the edge where the handshake completes.
- Back-to-back operation: one IDLE cycle minimum between the handshake and the next start.
- Reset is asynchronous on assertion. Release must be synchronous to clk externally; the first start is accepted at the first edge after release.

## Test plan
- IN_SIZE=4, LANES=2, NUM_NEURONS=2. in_data = {10,20,30,40}.
  - n0: weights 1111, bias 0. n1: weights 0101, bias -5.
  - Expect neuron_out = {100, 15} and neuron_sign = {1,1}. out_valid rises 3 edges after start; busy is high throughout.
- Tail masking: IN_SIZE=5, LANES=2, in_data = {1..5}, all weights 0, bias 3.
  - Expect neuron_out = -12 and neuron_sign = 0. N_BEATS = 3, so out_valid rises 4 edges after start.
- Same stimulus as the first case with en low for 2 cycles mid-ACCUM.
  - Expect identical results; out_valid is delayed by exactly 2 edges.
- Backpressure: out_ready low for 5 cycles after out_valid, start pulsed during DONE.
  - Expect outputs and out_valid held unchanged and start ignored.
  - Expect return to IDLE on the edge where out_ready goes high.
- Reset pulsed low mid-ACCUM.
  - Expect out_valid, busy and neuron_out at 0 immediately, without waiting for a clock edge.
  - A following start produces the correct first-case results.
- Defaults (IN_SIZE=784, LANES=8): all in_data = 255, all weights 0, bias 0.
  - Expect neuron_out = -199920 and neuron_sign = 0 on every neuron. N_BEATS = 98, so out_valid rises 99 edges after start.
